// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle control FSM, its output decode and the
// downstream ALU control unit.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // aluOp codes, also consumed by the ALU control unit
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memToReg;
        logic       regWrite;
        logic       regDst;
        logic       aluSrcA;
        logic [1:0] pcSource;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Pure combinational decode of FSM state into datapath controls.
// While reset is high it decodes FETCH with every write enable suppressed.
module control_decode
    import multicycle_control_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    input  logic   reset_i,
    output ctrl_t  ctrl_o
);

    state_e st;
    assign st = reset_i ? S_FETCH : state_i;

    // Per-state control decode; anything not set for a state stays 0
    always_comb begin
        ctrl_o = '0;
        case (st)
            S_FETCH: begin
                ctrl_o.memRead  = 1'b1;
                ctrl_o.aluSrcB  = SRCB_FOUR;
                ctrl_o.aluOp    = ALUOP_ADD;
                ctrl_o.pcSource = PCSRC_ALU;
                // Only latch IR / advance PC in the cycle the fetch completes
                ctrl_o.irWrite  = mem_ready_i && !reset_i;
                ctrl_o.pcWrite  = mem_ready_i && !reset_i;
            end
            S_DECODE: begin
                ctrl_o.aluSrcB = SRCB_IMMSH;
                ctrl_o.aluOp   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl_o.aluSrcA = 1'b1;
                ctrl_o.aluSrcB = SRCB_IMM;
                ctrl_o.aluOp   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.memRead = 1'b1;
                ctrl_o.iorD    = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.memWrite = 1'b1;
                ctrl_o.iorD     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.memToReg = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.aluSrcA = 1'b1;
                ctrl_o.aluSrcB = SRCB_REGB;
                ctrl_o.aluOp   = ALUOP_RTYPE;
            end
            S_RWB: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.regDst   = 1'b1;
            end
            S_ADDIWB: begin
                ctrl_o.regWrite = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.aluSrcA     = 1'b1;
                ctrl_o.aluSrcB     = SRCB_REGB;
                ctrl_o.aluOp       = ALUOP_SUB;
                ctrl_o.pcWriteCond = 1'b1;
                ctrl_o.pcSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pcWrite  = 1'b1;
                ctrl_o.pcSource = PCSRC_JUMP;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: state register and next-state logic,
// with output decode delegated to control_decode.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regWrite,
    output logic       regDst,
    output logic       aluSrcA,
    output logic [1:0] pcSource,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [3:0] state,
    output logic       illegalOp
);

    state_e state_q;
    logic   mem_rdy;
    ctrl_t  ctrl;

    // With waits disabled every memory access completes in one cycle
    assign mem_rdy = MEM_WAIT_EN ? memReady : 1'b1;

    // State register and transitions; opcode is only looked at in DECODE/MEMADR
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  if (mem_rdy) state_q <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state_q <= S_MEMADR;
                        OP_RTYPE:     state_q <= S_EXEC;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_J:         state_q <= S_JUMP;
                        OP_ADDI:      state_q <= S_ADDIEX;
                        default:      state_q <= S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    if (opcode == OP_LW)      state_q <= S_MEMRD;
                    else if (opcode == OP_SW) state_q <= S_MEMWR;
                    else                      state_q <= S_FETCH;
                end
                S_MEMRD:  if (mem_rdy) state_q <= S_MEMWB;
                S_MEMWR:  if (mem_rdy) state_q <= S_FETCH;
                S_EXEC:   state_q <= S_RWB;
                S_ADDIEX: state_q <= S_ADDIWB;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    control_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_rdy),
        .reset_i     (reset),
        .ctrl_o      (ctrl)
    );

    assign pcWrite     = ctrl.pcWrite;
    assign pcWriteCond = ctrl.pcWriteCond;
    assign iorD        = ctrl.iorD;
    assign memRead     = ctrl.memRead;
    assign memWrite    = ctrl.memWrite;
    assign irWrite     = ctrl.irWrite;
    assign memToReg    = ctrl.memToReg;
    assign regWrite    = ctrl.regWrite;
    assign regDst      = ctrl.regDst;
    assign aluSrcA     = ctrl.aluSrcA;
    assign pcSource    = ctrl.pcSource;
    assign aluSrcB     = ctrl.aluSrcB;
    assign aluOp       = ctrl.aluOp;

    // Debug state reads as FETCH while reset is held
    assign state     = reset ? S_FETCH : state_q;
    assign illegalOp = !reset && (state_q == S_DECODE) && !op_is_legal(opcode);

endmodule
